// File: rtl/harness_pkg.sv
// Shared types and constants for the simulation run-control harness.
package harness_pkg;

  // Harness run state: reset hold, running, and the two absorbing verdicts.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  // Encoding of the reason a run ended in FAIL.
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_TOHOST  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_STALL   = 2'd3;

  // Conventional tohost mailbox address used by the test programs.
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc, stick at all-ones, clear on i_clr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sim_harness_ctrl.sv
// Run-control harness: sequences core reset, counts run cycles and retires,
// watches the tohost mailbox and the timeout/stall watchdogs, and holds one
// sticky verdict until the next harness reset.
module sim_harness_ctrl
  import harness_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 2,
  parameter int                TIMEOUT_CYCLES = 20,
  parameter int                STALL_CYCLES   = 8,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_instr_retire,
  output logic              o_core_reset,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic [1:0]        o_fail_cause,
  output logic [DATA_W-2:0] o_fail_code,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [CNT_W-1:0]  o_retire_count
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES);

  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_CYCLES - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                r_core_reset;
  logic                r_running;
  logic                r_done;
  logic                r_pass;
  logic                r_fail;
  logic [1:0]          r_fail_cause;
  logic [DATA_W-2:0]   r_fail_code;

  logic                w_core_reset_next;
  logic                w_running_next;
  logic                w_done_next;
  logic                w_pass_next;
  logic                w_fail_next;
  logic [1:0]          w_fail_cause_next;
  logic [DATA_W-2:0]   w_fail_code_next;

  logic                w_run;
  logic                w_tohost_hit;
  logic                w_timeout;
  logic                w_stall;
  logic [CNT_W-1:0]    w_cycle_cnt;
  logic [CNT_W-1:0]    w_retire_cnt;
  logic [STALL_W-1:0]  w_stall_cnt;

  assign w_run = (r_state == RUN);

  // Only a tohost store with bit 0 set carries a verdict; even data is ignored.
  assign w_tohost_hit = i_st_valid && (i_st_addr == TOHOST_ADDR) && i_st_data[0];
  assign w_timeout    = (w_cycle_cnt == TIMEOUT_LAST);
  assign w_stall      = (w_stall_cnt == STALL_LAST) && !i_instr_retire;

  // Counters advance only in RUN, so they freeze once a verdict is reached.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_inc   (w_run),
    .o_count (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_inc   (w_run && i_instr_retire),
    .o_count (w_retire_cnt)
  );

  // The stall counter measures the current run of retire-free RUN cycles.
  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_run || i_instr_retire),
    .i_inc   (w_run),
    .o_count (w_stall_cnt)
  );

  // State, hold counter and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= HOLD;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_cause <= CAUSE_NONE;
      r_fail_code  <= '0;
    end else begin
      r_state      <= w_state_next;
      if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
      r_core_reset <= w_core_reset_next;
      r_running    <= w_running_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_fail       <= w_fail_next;
      r_fail_cause <= w_fail_cause_next;
      r_fail_code  <= w_fail_code_next;
    end
  end

  // Next state and verdict; tohost beats timeout, which beats stall.
  always_comb begin
    w_state_next      = r_state;
    w_pass_next       = r_pass;
    w_fail_next       = r_fail;
    w_fail_cause_next = r_fail_cause;
    w_fail_code_next  = r_fail_code;
    case (r_state)
      HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_tohost_hit) begin
          if (i_st_data == DATA_W'(1)) begin
            w_state_next = PASS;
            w_pass_next  = 1'b1;
          end else begin
            w_state_next      = FAIL;
            w_fail_next       = 1'b1;
            w_fail_cause_next = CAUSE_TOHOST;
            w_fail_code_next  = i_st_data[DATA_W-1:1];
          end
        end else if (w_timeout) begin
          w_state_next      = FAIL;
          w_fail_next       = 1'b1;
          w_fail_cause_next = CAUSE_TIMEOUT;
        end else if (w_stall) begin
          w_state_next      = FAIL;
          w_fail_next       = 1'b1;
          w_fail_cause_next = CAUSE_STALL;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register with it.
  always_comb begin
    w_core_reset_next = (w_state_next != RUN);
    w_running_next    = (w_state_next == RUN);
    w_done_next       = (w_state_next == PASS) || (w_state_next == FAIL);
  end

  assign o_core_reset   = r_core_reset;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_fail_cause   = r_fail_cause;
  assign o_fail_code    = r_fail_code;
  assign o_cycle_count  = w_cycle_cnt;
  assign o_retire_count = w_retire_cnt;

endmodule

// File: doc/sim_harness_ctrl.md
Name: sim_harness_ctrl

Overview:
- Synthesizable run-control harness placed between the bench and the pipelined core (`main`).
- Sequences the core's reset and counts run cycles and retired instructions.
- Watches the core's store bus for a tohost write to decide PASS or FAIL.
- Enforces a global timeout and a retire-stall watchdog, and reports one sticky verdict.
- Replaces fixed-delay `$finish` benches: one bench serves any program length.

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, store data width
CNT_W, 32, width of cycle and retire counters
RESET_CYCLES, 2, cycles core_reset is held after harness reset release (min 1)
TIMEOUT_CYCLES, 20, max RUN cycles before TIMEOUT verdict (min 2)
STALL_CYCLES, 8, max consecutive RUN cycles without a retire before STALL verdict (min 2)
TOHOST_ADDR, 32'h0000_0100, store address that carries the verdict

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low harness reset
st_valid  in  1  core store strobe, one per store
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
instr_retire  in  1  core retired one instruction this cycle
core_reset  out  1  active-high reset to core, registered
running  out  1  high in RUN state
done  out  1  sticky; high in any terminal state
pass  out  1  sticky PASS verdict
fail  out  1  sticky FAIL verdict (tohost fail, timeout or stall)
fail_cause  out  2  0 none, 1 tohost, 2 timeout, 3 stall
fail_code  out  DATA_W-1  st_data>>1 from the failing tohost write, else 0
cycle_count  out  CNT_W  RUN cycles elapsed, saturating
retire_count  out  CNT_W  instructions retired in RUN, saturating

Behaviour:
- Reset: reset low asynchronously forces the following, from any state including mid-run:
  - core_reset=1, running=0, done=0, pass=0, fail=0, fail_cause=0, fail_code=0, counters=0.
  - State goes to HOLD.
- HOLD:
  - Hold counter increments each cycle; core_reset stays 1.
  - After RESET_CYCLES rising edges following reset release, go to RUN.
  - core_reset=0 and running=1 from that edge onward.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - retire_count increments on instr_retire, saturating at all-ones.
  - Stall counter clears on instr_retire and otherwise increments.
- Exit conditions from RUN, evaluated in one cycle in this priority order:
  - 1. st_valid && st_addr==TOHOST_ADDR && st_data[0]==1:
    - st_data==1 -> PASS.
    - Otherwise -> FAIL, fail_cause=1, fail_code=st_data[DATA_W-1:1].
  - 2. tohost write with st_data[0]==0 is ignored; non-tohost stores are ignored.
  - 3. cycle_count==TIMEOUT_CYCLES-1 -> FAIL, fail_cause=2.
  - 4. Stall counter==STALL_CYCLES-1 and no retire this cycle -> FAIL, fail_cause=3.
- Terminal states PASS and FAIL:
  - Absorbing until reset.
  - Verdict outputs register on the edge leaving RUN.
  - done=1; running=0; core_reset returns to 1 to freeze the core.
  - Counters freeze.
  - Further stores and retires are ignored; the first verdict is never overwritten.
- Simultaneous events: tohost write in the same cycle as timeout or stall -> tohost verdict wins.
- Exactly one of pass/fail is high whenever done=1; both are low when done=0.
- All outputs are registered, with no combinational paths from inputs.

Decomposition:
- Package harness_pkg holds:
  - State enum: HOLD, RUN, PASS, FAIL.
  - fail_cause constants: CAUSE_NONE, CAUSE_TOHOST, CAUSE_TIMEOUT, CAUSE_STALL.
  - Default TOHOST_ADDR localparam.
- Sub-module sat_counter (parameter W, inputs clr and inc, output count) provides saturating increment.
  - Instanced for cycle_count, retire_count and the stall counter.

Test Plan:
- Reset low 3 cycles, then released -> core_reset=1 for exactly 2 edges, then 0; running=1; cycle_count counts from 0.
- Retire every cycle; at RUN cycle 5, store addr=0x100 data=1 -> next edge pass=1, done=1, core_reset=1; cycle_count frozen at 6.
- Store addr=0x100 data=0x0000_0007 -> fail=1, fail_cause=1, fail_code=3; a later data=1 store leaves the verdict unchanged.
- Retire every cycle with no tohost -> fail_cause=2 after 20 RUN cycles.
- Tohost data=1 on the timeout cycle -> pass wins.
- Retire stops after cycle 4 -> fail_cause=3 exactly 8 cycles later; a data=0 tohost write mid-run has no effect.
- Reset asserted mid-RUN and in FAIL -> all outputs return to reset values immediately, without waiting for a clock edge.
- After reset release, HOLD/RUN repeats cleanly.
